mem_arbiter: RTL

//  Two-port front end for the single-port 16-bit word memory (sync read, 1-cycle latency).

---
 rtl/mem_arb_pkg.sv | 13 +
 rtl/arb_starve_ctr.sv | 29 ++
 rtl/mem_arbiter.sv | 97 +++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the two-port memory arbiter.
package mem_arb_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// Fetch starvation counter: raises o_force once fetch has been denied STARVE_LIMIT cycles in a row.
module arb_starve_ctr #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic if_req,
  input  logic if_gnt,
  output logic o_force
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (!if_req || if_gnt) begin
      r_cnt <= '0;
    end else if (r_cnt != LIM) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_force = if_req && (r_cnt == LIM);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data requests onto one sync-read memory port and routes read data back.
// Optional fetch anti-starvation is enabled by defining ARB_FAIR_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEMORY_SIZE  = 256,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_enable,
  input  logic [DATA_W-1:0] mem_read_data
);

  localparam logic [ADDR_W:0] MEM_LIM = (ADDR_W + 1)'(MEMORY_SIZE);

  logic   w_force;
  logic   w_if_gnt;
  logic   w_d_gnt;
  logic   w_d_oor;
  owner_t r_owner;
  logic   r_err;

`ifdef ARB_FAIR_EN
  arb_starve_ctr #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk     (clk),
    .reset   (reset),
    .if_req  (if_req),
    .if_gnt  (w_if_gnt),
    .o_force (w_force)
  );
`else
  assign w_force = 1'b0;
`endif

  // Data wins by default; a forced fetch overrides it for one cycle.
  assign w_d_gnt  = d_req && !w_force;
  assign w_if_gnt = if_req && (!d_req || w_force);
  assign if_gnt   = w_if_gnt;
  assign d_gnt    = w_d_gnt;

  assign w_d_oor  = ({1'b0, d_addr} >= MEM_LIM);

  always_comb begin
    mem_address      = '0;
    mem_write_data   = '0;
    mem_write_enable = 1'b0;
    if (w_d_gnt) begin
      mem_address      = d_addr;
      mem_write_data   = d_wdata;
      mem_write_enable = d_we;
    end else if (w_if_gnt) begin
      mem_address      = if_addr;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_owner <= OWN_NONE;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_d_gnt && w_d_oor;
      if (w_d_gnt && !d_we) begin
        r_owner <= OWN_D;
      end else if (w_if_gnt) begin
        r_owner <= OWN_IF;
      end else begin
        r_owner <= OWN_NONE;
      end
    end
  end

  // Owner register selects which requester sees this cycle's memory read data.
  assign if_rvalid = (r_owner == OWN_IF);
  assign d_rvalid  = (r_owner == OWN_D);
  assign d_err     = r_err;
  assign if_rdata  = if_rvalid ? mem_read_data : '0;
  assign d_rdata   = (d_rvalid && !r_err) ? mem_read_data : '0;

endmodule
